// File: rtl/zigzag_reorder.sv
// Zigzag reorder stage: takes raster rows of a quantized 8x8 block and emits
// the block as eight zigzag-ordered groups, ping-ponging between two banks.
//
// Ports:
//   clk        rising-edge clock
//   reset      synchronous, active-low reset
//   in_valid   a raster row is present on in this cycle
//   in         8 coefficients of one row, column 0 in the MSBs
//   out_valid  out holds a zigzag group
//   out        zigzag positions 8g..8g+7, position 8g in the MSBs
//   out_first  high with group 0 of a block
//   out_last   high with group 7 of a block
module zigzag_reorder #(
    parameter int DW = 8
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    input  logic [8*DW-1:0] in,
    output logic            out_valid,
    output logic [8*DW-1:0] out,
    output logic            out_first,
    output logic            out_last
);

    // Raster index of each zigzag position.
    localparam logic [5:0] ZZ [64] = '{
        6'd0,  6'd1,  6'd8,  6'd16, 6'd9,  6'd2,  6'd3,  6'd10,
        6'd17, 6'd24, 6'd32, 6'd25, 6'd18, 6'd11, 6'd4,  6'd5,
        6'd12, 6'd19, 6'd26, 6'd33, 6'd40, 6'd48, 6'd41, 6'd34,
        6'd27, 6'd20, 6'd13, 6'd6,  6'd7,  6'd14, 6'd21, 6'd28,
        6'd35, 6'd42, 6'd49, 6'd56, 6'd57, 6'd50, 6'd43, 6'd36,
        6'd29, 6'd22, 6'd15, 6'd23, 6'd30, 6'd37, 6'd44, 6'd51,
        6'd58, 6'd59, 6'd52, 6'd45, 6'd38, 6'd31, 6'd39, 6'd46,
        6'd53, 6'd60, 6'd61, 6'd54, 6'd47, 6'd55, 6'd62, 6'd63
    };

    typedef enum logic {
        S_IDLE,
        S_READ
    } state_t;

    logic [DW-1:0]   mem [2][64];

    state_t          state;
    state_t          state_d;
    logic [2:0]      wr_row;
    logic [2:0]      wr_row_d;
    logic            wr_bank;
    logic            wr_bank_d;
    logic [1:0]      full;
    logic [1:0]      full_d;
    logic            rd_bank;
    logic            rd_bank_d;
    logic [2:0]      rd_grp;
    logic [2:0]      rd_grp_d;

    logic            load;
    logic [2:0]      cur_grp;
    logic [8*DW-1:0] word;

    // Next-state logic. Write and read sides update full[] independently;
    // the invariant keeps them on different banks whenever both fire.
    always_comb begin
        state_d   = state;
        wr_row_d  = wr_row;
        wr_bank_d = wr_bank;
        full_d    = full;
        rd_bank_d = rd_bank;
        rd_grp_d  = rd_grp;
        load      = 1'b0;
        cur_grp   = 3'd0;

        if (in_valid) begin
            wr_row_d = wr_row + 3'd1;
            if (wr_row == 3'd7) begin
                full_d[wr_bank] = 1'b1;
                wr_bank_d       = ~wr_bank;
            end
        end

        unique case (state)
            S_IDLE: begin
                if (full[rd_bank]) begin
                    load     = 1'b1;
                    cur_grp  = 3'd0;
                    rd_grp_d = 3'd1;
                    state_d  = S_READ;
                end
            end
            S_READ: begin
                load    = 1'b1;
                cur_grp = rd_grp;
                if (rd_grp == 3'd7) begin
                    full_d[rd_bank] = 1'b0;
                    rd_bank_d       = ~rd_bank;
                    rd_grp_d        = 3'd0;
                    state_d         = S_IDLE;
                end else begin
                    rd_grp_d = rd_grp + 3'd1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Gather the eight coefficients of the group being loaded.
    always_comb begin
        word = '0;
        for (int k = 0; k < 8; k++) begin
            word[8*DW-1-k*DW -: DW] = mem[rd_bank][ZZ[{cur_grp, 3'(k)}]];
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= S_IDLE;
            wr_row    <= 3'd0;
            wr_bank   <= 1'b0;
            full      <= 2'b00;
            rd_bank   <= 1'b0;
            rd_grp    <= 3'd0;
            out_valid <= 1'b0;
            out       <= '0;
            out_first <= 1'b0;
            out_last  <= 1'b0;
        end else begin
            state   <= state_d;
            wr_row  <= wr_row_d;
            wr_bank <= wr_bank_d;
            full    <= full_d;
            rd_bank <= rd_bank_d;
            rd_grp  <= rd_grp_d;
            if (load) begin
                out_valid <= 1'b1;
                out       <= word;
                out_first <= (cur_grp == 3'd0);
                out_last  <= (cur_grp == 3'd7);
            end else begin
                out_valid <= 1'b0;
                out_first <= 1'b0;
                out_last  <= 1'b0;
            end
        end
    end

    // Bank RAM is not cleared by reset.
    always_ff @(posedge clk) begin
        if (reset && in_valid) begin
            for (int c = 0; c < 8; c++) begin
                mem[wr_bank][{wr_row, 3'(c)}] <= in[8*DW-1-c*DW -: DW];
            end
        end
    end

endmodule

// File: tb/tb_zigzag_reorder.sv
// Self-checking bench for zigzag_reorder: scoreboard of expected zigzag
// groups compared against captured output words.
module tb_zigzag_reorder;

    localparam int DW = 8;

    typedef logic [7:0] blk_t [64];
    typedef struct packed {
        logic [63:0] d;
        logic        f;
        logic        l;
    } word_t;
    typedef struct {
        word_t w;
        int    c;
    } obs_t;

    localparam int ZZ [64] = '{
        0, 1, 8, 16, 9, 2, 3, 10, 17, 24, 32, 25, 18, 11, 4, 5,
        12, 19, 26, 33, 40, 48, 41, 34, 27, 20, 13, 6, 7, 14, 21, 28,
        35, 42, 49, 56, 57, 50, 43, 36, 29, 22, 15, 23, 30, 37, 44, 51,
        58, 59, 52, 45, 38, 31, 39, 46, 53, 60, 61, 54, 47, 55, 62, 63
    };

    logic          clk;
    logic          reset;
    logic          in_valid;
    logic [63:0]   din;
    logic          out_valid;
    logic [63:0]   dout;
    logic          out_first;
    logic          out_last;

    int            cyc;
    int            n_checks;
    int            n_fail;
    int            last_row_cyc;
    word_t         exp_q[$];
    obs_t          obs_q[$];
    blk_t          blk_a;
    blk_t          blk_b;

    zigzag_reorder #(.DW(DW)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in        (din),
        .out_valid (out_valid),
        .out       (dout),
        .out_first (out_first),
        .out_last  (out_last)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Capture every valid output word with the edge count that produced it.
    always @(negedge clk) begin
        if (out_valid === 1'b1) begin
            obs_t o;
            o.w = {dout, out_first, out_last};
            o.c = cyc;
            obs_q.push_back(o);
        end
    end

    // An accepted row must never target a bank still waiting to be read.
    always @(posedge clk) begin
        if (reset === 1'b1 && in_valid === 1'b1) begin
            n_checks++;
            if (dut.full[dut.wr_bank] !== 1'b0) begin
                n_fail++;
                $display("FAIL overflow: row accepted into full bank %0d at cycle %0d",
                         dut.wr_bank, cyc);
            end
        end
    end

    function automatic word_t zz_word(input blk_t b, input int g);
        word_t w;
        for (int k = 0; k < 8; k++) begin
            w.d[63-8*k -: 8] = b[ZZ[8*g+k]];
        end
        w.f = (g == 0);
        w.l = (g == 7);
        return w;
    endfunction

    // gap: 0 none, 1 one idle cycle between rows, 2 random 0..2 idles.
    task automatic send_block(input blk_t b, input int gap,
                              input int nrows, input int nexp);
        for (int g = 0; g < nexp; g++) exp_q.push_back(zz_word(b, g));
        for (int r = 0; r < nrows; r++) begin
            int ng;
            ng = 0;
            if (gap == 1 && r > 0) ng = 1;
            if (gap == 2) ng = int'($urandom_range(0, 2));
            repeat (ng) begin
                @(negedge clk);
                in_valid = 1'b0;
                din      = {$urandom, $urandom};
            end
            @(negedge clk);
            in_valid = 1'b1;
            for (int c = 0; c < 8; c++) din[63-8*c -: 8] = b[r*8+c];
            last_row_cyc = cyc + 1;
        end
    endtask

    task automatic idle(input int n);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (n - 1) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        in_valid = 1'b0;
        reset    = 1'b0;
        @(negedge clk);
        reset    = 1'b1;
        exp_q.delete();
        obs_q.delete();
    endtask

    task automatic test_reset();
        reset    = 1'b0;
        in_valid = 1'b1;
        din      = 64'hFFEE_DDCC_BBAA_9988;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({out_valid, dout, out_first, out_last} !== 67'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got v=%b out=%h f=%b l=%b, want all 0",
                     out_valid, dout, out_first, out_last);
        end
        in_valid = 1'b0;
        reset    = 1'b1;
        exp_q.delete();
        obs_q.delete();
    endtask

    task automatic test_single_block();
        do_reset();
        send_block(blk_a, 0, 8, 8);
        idle(14);
        n_checks++;
        if (obs_q.size() != 8) begin
            n_fail++;
            $display("FAIL single_count: got %0d words, want 8", obs_q.size());
        end
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            n_checks++;
            if (obs_q[i].w !== exp_q[i]) begin
                n_fail++;
                $display("FAIL single_word%0d: got %h, want %h", i, obs_q[i].w, exp_q[i]);
            end
        end
        if (obs_q.size() == 8) begin
            n_checks++;
            if (obs_q[0].w.d !== 64'h000108100902030A || obs_q[0].w.f !== 1'b1) begin
                n_fail++;
                $display("FAIL single_g0: got %h f=%b, want 000108100902030a f=1",
                         obs_q[0].w.d, obs_q[0].w.f);
            end
            n_checks++;
            if (obs_q[7].w.d !== 64'h353C3D362F373E3F || obs_q[7].w.l !== 1'b1) begin
                n_fail++;
                $display("FAIL single_g7: got %h l=%b, want 353c3d362f373e3f l=1",
                         obs_q[7].w.d, obs_q[7].w.l);
            end
            n_checks++;
            if (obs_q[0].c != last_row_cyc + 1 || obs_q[7].c != last_row_cyc + 8) begin
                n_fail++;
                $display("FAIL single_latency: got g0@%0d g7@%0d, want %0d and %0d",
                         obs_q[0].c, obs_q[7].c, last_row_cyc + 1, last_row_cyc + 8);
            end
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        send_block(blk_a, 0, 8, 8);
        send_block(blk_b, 0, 8, 8);
        idle(20);
        n_checks++;
        if (obs_q.size() != 16) begin
            n_fail++;
            $display("FAIL b2b_count: got %0d words, want 16", obs_q.size());
        end
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            n_checks++;
            if (obs_q[i].w !== exp_q[i] || obs_q[i].c != obs_q[0].c + i) begin
                n_fail++;
                $display("FAIL b2b_word%0d: got %h @%0d, want %h @%0d",
                         i, obs_q[i].w, obs_q[i].c, exp_q[i], obs_q[0].c + i);
            end
        end
        if (obs_q.size() == 16) begin
            n_checks++;
            if (obs_q[8].w.d !== 64'h404148504942434A || obs_q[8].w.f !== 1'b1) begin
                n_fail++;
                $display("FAIL b2b_b_g0: got %h f=%b, want 404148504942434a f=1",
                         obs_q[8].w.d, obs_q[8].w.f);
            end
        end
    endtask

    task automatic test_gaps();
        do_reset();
        send_block(blk_a, 1, 8, 8);
        idle(14);
        n_checks++;
        if (obs_q.size() != 8) begin
            n_fail++;
            $display("FAIL gaps_count: got %0d words, want 8", obs_q.size());
        end
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            n_checks++;
            if (obs_q[i].w !== exp_q[i]) begin
                n_fail++;
                $display("FAIL gaps_word%0d: got %h, want %h", i, obs_q[i].w, exp_q[i]);
            end
        end
        if (obs_q.size() > 0) begin
            n_checks++;
            if (obs_q[0].c != last_row_cyc + 1) begin
                n_fail++;
                $display("FAIL gaps_latency: got g0@%0d, want %0d",
                         obs_q[0].c, last_row_cyc + 1);
            end
        end
    endtask

    task automatic test_reset_readout();
        int e;
        do_reset();
        send_block(blk_a, 0, 8, 4);
        e = last_row_cyc;
        for (int t = 0; t < 10 && cyc < e + 4; t++) begin
            @(negedge clk);
            in_valid = 1'b0;
        end
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        n_checks++;
        if (out_valid !== 1'b0 || dout !== 64'd0) begin
            n_fail++;
            $display("FAIL rdreset_outputs: got v=%b out=%h, want v=0 out=0",
                     out_valid, dout);
        end
        send_block(blk_b, 0, 8, 8);
        idle(14);
        n_checks++;
        if (obs_q.size() != 12) begin
            n_fail++;
            $display("FAIL rdreset_count: got %0d words, want 12", obs_q.size());
        end
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            n_checks++;
            if (obs_q[i].w !== exp_q[i]) begin
                n_fail++;
                $display("FAIL rdreset_word%0d: got %h, want %h", i, obs_q[i].w, exp_q[i]);
            end
        end
    endtask

    task automatic test_reset_partial();
        do_reset();
        send_block(blk_a, 0, 5, 0);
        @(negedge clk);
        in_valid = 1'b0;
        reset    = 1'b0;
        @(negedge clk);
        reset    = 1'b1;
        send_block(blk_b, 0, 8, 8);
        idle(14);
        n_checks++;
        if (obs_q.size() != 8) begin
            n_fail++;
            $display("FAIL partial_count: got %0d words, want 8", obs_q.size());
        end
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            n_checks++;
            if (obs_q[i].w !== exp_q[i]) begin
                n_fail++;
                $display("FAIL partial_word%0d: got %h, want %h", i, obs_q[i].w, exp_q[i]);
            end
        end
    endtask

    task automatic test_random_stream();
        blk_t b;
        do_reset();
        for (int n = 0; n < 20; n++) begin
            for (int i = 0; i < 64; i++) b[i] = 8'($urandom);
            send_block(b, 2, 8, 8);
        end
        idle(16);
        n_checks++;
        if (obs_q.size() != 160) begin
            n_fail++;
            $display("FAIL random_count: got %0d words, want 160", obs_q.size());
        end
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            n_checks++;
            if (obs_q[i].w !== exp_q[i]) begin
                n_fail++;
                $display("FAIL random_word%0d: got %h, want %h", i, obs_q[i].w, exp_q[i]);
            end
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        reset    = 1'b0;
        in_valid = 1'b0;
        din      = 64'd0;
        for (int i = 0; i < 64; i++) begin
            blk_a[i] = 8'(i);
            blk_b[i] = 8'(8'h40 + i);
        end
        test_reset();
        test_single_block();
        test_back_to_back();
        test_gaps();
        test_reset_readout();
        test_reset_partial();
        test_random_stream();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/zigzag_reorder.md
Name: zigzag_reorder

Overview:
Double-buffered zigzag reorder stage that sits directly upstream of the run-length encoder. It accepts one 8-coefficient raster row of a quantized 8x8 block per accepted cycle, in the same 64-bit packing the RLE consumes. It emits the block as eight 64-bit words in JPEG zigzag order, one word per cycle. Ping-pong banks allow block N+1 to be written while block N is read, so a continuous row stream yields a continuous output stream.

Parameters:
DW, 8, coefficient width in bits; data buses are 8*DW wide.

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous, active-low reset
in_valid  input  1  a raster row is present on in this cycle
in  input  8*DW  row r, column c at bits [8*DW-1-c*DW -: DW]; column 0 in MSBs
out_valid  output  1  out holds a zigzag group
out  output  8*DW  zigzag positions 8g..8g+7; position 8g in MSBs
out_first  output  1  high with group 0 of a block
out_last  output  1  high with group 7 of a block

Behaviour:
- Interface (already decided): one clock, clk. Reset is synchronous and active-low, named reset, sampled only on rising clk.
- Reset (reset==0 at an edge):
  - out_valid=0, out=0, out_first=0, out_last=0.
  - Write row counter=0, write bank=0, read group counter=0, read bank=0.
  - Both bank-full flags=0. Bank RAM contents are not cleared.
  - A partially written block, or one mid-readout, is discarded. No output from it appears after reset is released.
- Storage: 2 banks x 64 coefficients x DW bits.
- Write side:
  - On each edge with in_valid=1, store the 8 coefficients of in at raster indices wr_row*8+c, c=0..7, in bank wr_bank. Increment wr_row (3-bit, wraps).
  - When row 7 is captured: set full[wr_bank] and toggle wr_bank.
  - Gaps in in_valid are allowed anywhere; wr_row holds through gaps.
- Read side:
  - Start condition: at an edge where not reading and full[rd_bank]=1. Begin readout with group 0 loaded into the registered out.
  - During readout, each edge loads the next group. Groups 0..7 appear on 8 consecutive cycles with out_valid=1.
  - Group g word = coefficients at raster indices ZZ[8g..8g+7].
  - ZZ = 0,1,8,16,9,2,3,10, 17,24,32,25,18,11,4,5, 12,19,26,33,40,48,41,34, 27,20,13,6,7,14,21,28, 35,42,49,56,57,50,43,36, 29,22,15,23,30,37,44,51, 58,59,52,45,38,31,39,46, 53,60,61,54,47,55,62,63.
  - On the edge that loads group 7: clear full[rd_bank] and toggle rd_bank.
  - If the other bank is already full, the following edge loads its group 0 with no bubble. Otherwise out_valid=0 and out holds its last value.
- Latency:
  - Row 7 captured at edge E gives group 0 visible after edge E+1, group 7 after edge E+8.
  - There is no backpressure. The RLE consumes one word per cycle.
- No-overflow invariant:
  - A bank drains in 8 cycles, and refilling the other bank takes at least 8 cycles. An accepted row can therefore never target a full bank.
  - The bench asserts that full[wr_bank]==0 whenever in_valid=1.
- Simultaneous events: full[x] set by the write side and full[y] cleared by the read side on the same edge is legal, and both updates take effect.
- out_first and out_last are registered alongside out. They are 0 whenever out_valid=0.

Test Plan:
1. Reset, then block A with in = raster values 0x00..0x3F, rows on 8 consecutive edges -> after edge 9, out=0x0001081009020 30A with out_first=1, i.e. bytes 00,01,08,10,09,02,03,0A. After edge 16, bytes 35,3C,3D,36,2F,37,3E,3F with out_last=1.
2. Block A then block B (values 0x40+raster index) back to back for 16 edges -> out_valid high for 16 consecutive cycles. B group 0 bytes are 40,41,48,50,49,42,43,4A, with out_first=1 directly after A's out_last.
3. Block A rows with in_valid toggling 1,0 every cycle -> output identical to scenario 1. out_valid asserts one edge after row 7 is captured.
4. Block A written, reset=0 for one edge during readout group 3, then block B written -> no A groups after reset. B readout is correct, starting with out_first=1.
5. 5 rows of A, reset=0 for one edge, then full block B -> output is exactly B's 8 groups, with no mix of A data.
6. 20 random blocks streamed with random in_valid gaps -> every output word matches a reference zigzag model. The full[wr_bank]==0 assertion never fires.
